// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, data-memory
// wait handling with timeout, and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             IF_ID_use_rs,
  input  logic             IF_ID_use_rt,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd_dst,
  input  logic             Branch_taken_EX,
  input  logic             Jump_ID,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              mem_err_q;
  logic              load_use;
  logic              mem_stall;
  logic              freeze;

  assign load_use = ID_EX_MemRead && (ID_EX_rd_dst != 5'd0) &&
                    ((IF_ID_use_rs && (IF_ID_rs == ID_EX_rd_dst)) ||
                     (IF_ID_use_rt && (IF_ID_rt == ID_EX_rd_dst)));
  assign mem_stall = mem_req && !mem_ready;
  assign wait_nxt  = wait_cnt + 1'b1;

  // A memory wait that has just completed is decoded exactly like RUN.
  assign freeze = !reset || (state_q == ERROR) ||
                  ((state_q == MEM_WAIT) && !mem_ready);

  always_comb begin
    PC_write     = 1'b0;
    IF_ID_write  = 1'b0;
    ID_EX_write  = 1'b0;
    EX_MEM_write = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    if (!freeze && !mem_stall) begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_write  = 1'b1;
      EX_MEM_write = 1'b1;
      if (Branch_taken_EX) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (load_use) begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
      end else if (Jump_ID) begin
        IF_ID_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q  <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q <= RUN;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_W'(MEM_TIMEOUT)) begin
              state_q   <= ERROR;
              mem_err_q <= 1'b1;
            end
          end
        end
        ERROR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_write && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if ((IF_ID_flush || ID_EX_flush) && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard priorities, memory wait, timeout
// and counter saturation, with hand-computed expected values.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rd_dst;
  logic       IF_ID_use_rs, IF_ID_use_rt, ID_EX_MemRead;
  logic       Branch_taken_EX, Jump_ID, mem_req, mem_ready;

  logic        PC_write, IF_ID_write, ID_EX_write, EX_MEM_write;
  logic        IF_ID_flush, ID_EX_flush, mem_err;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_PC_write, s_IF_ID_write, s_ID_EX_write, s_EX_MEM_write;
  logic        s_IF_ID_flush, s_ID_EX_flush, s_mem_err;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int compared   = 0;
  int mismatched = 0;
  int waited;

  logic [3:0] wr;
  logic [1:0] fl;
  assign wr = {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write};
  assign fl = {IF_ID_flush, ID_EX_flush};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .IF_ID_use_rs(IF_ID_use_rs), .IF_ID_use_rt(IF_ID_use_rt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd_dst(ID_EX_rd_dst),
    .Branch_taken_EX(Branch_taken_EX), .Jump_ID(Jump_ID),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .state(state), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy driven by the same stimulus, used for saturation.
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .IF_ID_use_rs(IF_ID_use_rs), .IF_ID_use_rt(IF_ID_use_rt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd_dst(ID_EX_rd_dst),
    .Branch_taken_EX(Branch_taken_EX), .Jump_ID(Jump_ID),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_write(s_PC_write), .IF_ID_write(s_IF_ID_write),
    .ID_EX_write(s_ID_EX_write), .EX_MEM_write(s_EX_MEM_write),
    .IF_ID_flush(s_IF_ID_flush), .ID_EX_flush(s_ID_EX_flush),
    .state(s_state), .mem_err(s_mem_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Drives one cycle's inputs just after the falling edge and lets them settle.
  task automatic applyStimulus(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urs, input logic urt,
                               input logic br, input logic jmp, input logic mreq,
                               input logic mrdy);
    @(negedge clk);
    ID_EX_MemRead   = mr;
    ID_EX_rd_dst    = rd;
    IF_ID_rs        = rs;
    IF_ID_rt        = rt;
    IF_ID_use_rs    = urs;
    IF_ID_use_rt    = urt;
    Branch_taken_EX = br;
    Jump_ID         = jmp;
    mem_req         = mreq;
    mem_ready       = mrdy;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    idle();
    checkOutput("rst_state", state, 0);
    checkOutput("rst_mem_err", mem_err, 0);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    checkOutput("rst_flush_cnt", flush_cnt, 0);
    checkOutput("rst_writes", wr, 4'b0000);
    checkOutput("rst_flushes", fl, 2'b00);

    @(negedge clk);
    reset = 1'b1;
    idle();
    checkOutput("post_rst_writes", wr, 4'b1111);
    checkOutput("post_rst_flushes", fl, 2'b00);
    checkOutput("post_rst_state", state, 0);

    // load-use through rs: one bubble
    applyStimulus(1, 8, 8, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("lu_writes", wr, 4'b0011);
    checkOutput("lu_flushes", fl, 2'b01);
    idle();
    checkOutput("lu_writes_after", wr, 4'b1111);
    checkOutput("lu_stall_cnt", stall_cnt, 1);
    checkOutput("lu_flush_cnt", flush_cnt, 1);

    // destination $0 never creates a hazard
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("r0_writes", wr, 4'b1111);
    checkOutput("r0_flushes", fl, 2'b00);

    // matching register that is not read is no hazard; matching rt that is read is
    applyStimulus(1, 5, 5, 3, 0, 1, 0, 0, 0, 0);
    checkOutput("unused_rs_writes", wr, 4'b1111);
    applyStimulus(1, 5, 0, 5, 0, 1, 0, 0, 0, 0);
    checkOutput("lu_rt_writes", wr, 4'b0011);
    checkOutput("lu_rt_flushes", fl, 2'b01);
    idle();
    checkOutput("lu_rt_stall_cnt", stall_cnt, 2);
    checkOutput("lu_rt_flush_cnt", flush_cnt, 2);

    // branch overrides a concurrent load-use
    applyStimulus(1, 8, 8, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("br_lu_writes", wr, 4'b1111);
    checkOutput("br_lu_flushes", fl, 2'b11);
    idle();
    checkOutput("br_stall_cnt", stall_cnt, 2);
    checkOutput("br_flush_cnt", flush_cnt, 3);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("jmp_writes", wr, 4'b1111);
    checkOutput("jmp_flushes", fl, 2'b10);

    // load-use outranks a jump
    applyStimulus(1, 9, 9, 0, 1, 0, 0, 1, 0, 0);
    checkOutput("jmp_lu_writes", wr, 4'b0011);
    checkOutput("jmp_lu_flushes", fl, 2'b01);
    idle();
    checkOutput("jmp_lu_stall_cnt", stall_cnt, 3);
    checkOutput("jmp_lu_flush_cnt", flush_cnt, 5);
    checkOutput("sat_stall_cnt_3", s_stall_cnt, 3);

    // memory wait: three not-ready cycles (stall beats a branch), then ready
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("mw0_state", state, 0);
    checkOutput("mw0_writes", wr, 4'b0000);
    checkOutput("mw0_flushes", fl, 2'b00);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("mw1_state", state, 1);
    checkOutput("mw1_writes", wr, 4'b0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("mw2_state", state, 1);
    checkOutput("mw2_writes", wr, 4'b0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("mw_done_state", state, 1);
    checkOutput("mw_done_writes", wr, 4'b1111);
    idle();
    checkOutput("mw_back_state", state, 0);
    checkOutput("mw_stall_cnt", stall_cnt, 6);
    checkOutput("mw_flush_cnt", flush_cnt, 5);
    checkOutput("sat_stall_cnt_held", s_stall_cnt, 3);
    checkOutput("sat_flush_cnt", s_flush_cnt, 3);

    // timeout: ready held low until ERROR
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    waited = 0;
    while (state != 2'd2 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("to_state", state, 2);
    checkOutput("to_cycles", waited, 5);
    checkOutput("to_mem_err", mem_err, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("err_ready_state", state, 2);
    checkOutput("err_ready_writes", wr, 4'b0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("err_hold_state", state, 2);
    checkOutput("err_hold_mem_err", mem_err, 1);
    checkOutput("err_hold_writes", wr, 4'b0000);
    checkOutput("err_hold_flushes", fl, 2'b00);

    // asynchronous reset out of ERROR, mid-cycle
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_state", state, 0);
    checkOutput("async_rst_mem_err", mem_err, 0);
    checkOutput("async_rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    checkOutput("rerun_writes", wr, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
